// File: rtl/universal_register_pkg.sv
// Shared definitions for the universal datapath register: operation encodings
// used by the register and by the control-word decoder.
package universal_register_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_INC  = 3'd6,
        MODE_DEC  = 3'd7
    } mode_e;

endpackage

// File: rtl/universal_register_dff_r.sv
// Single-bit rising-edge D flip-flop whose asynchronous active-low clear
// loads a per-instance reset value.
module universal_register_dff_r (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    input  logic rst_val,
    output logic q
);

    // Storage bit with asynchronous clear to rst_val
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= rst_val;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/universal_register.sv
// Multi-mode WIDTH-bit datapath register: hold, load, shift, rotate, increment
// and decrement, with carry/zero flags and a gated tri-state bus driver.
module universal_register
    import universal_register_pkg::*;
#(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic             ser_in,
    input  logic             out_en,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] bus_out,
    output logic             carry,
    output logic             zero
);

    localparam int M = WIDTH - 1;

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic             carry_d;
    logic             carry_q;

    // Next-state selection; unknown or unlisted encodings fall back to hold
    always_comb begin
        q_d     = q_q;
        carry_d = carry_q;
        case (mode)
            MODE_HOLD: begin
                q_d     = q_q;
                carry_d = carry_q;
            end
            MODE_LOAD: begin
                q_d     = data;
                carry_d = 1'b0;
            end
            MODE_SHL: begin
                q_d     = {q_q[M-1:0], ser_in};
                carry_d = q_q[M];
            end
            MODE_SHR: begin
                q_d     = {ser_in, q_q[M:1]};
                carry_d = q_q[0];
            end
            MODE_ROL: begin
                q_d     = {q_q[M-1:0], q_q[M]};
                carry_d = q_q[M];
            end
            MODE_ROR: begin
                q_d     = {q_q[0], q_q[M:1]};
                carry_d = q_q[0];
            end
            MODE_INC: begin
                {carry_d, q_d} = {1'b0, q_q} + {{WIDTH{1'b0}}, 1'b1};
            end
            MODE_DEC: begin
                q_d     = q_q - {{(WIDTH-1){1'b0}}, 1'b1};
                carry_d = (q_q == {WIDTH{1'b0}});
            end
            default: begin
                q_d     = q_q;
                carry_d = carry_q;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_q_bit
        universal_register_dff_r u_q_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .d       (q_d[i]),
            .rst_val (RESET_VALUE[i]),
            .q       (q_q[i])
        );
    end

    universal_register_dff_r u_carry (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (carry_d),
        .rst_val (1'b0),
        .q       (carry_q)
    );

    assign q       = q_q;
    assign carry   = carry_q;
    // zero tracks q combinationally so it is valid in the same cycle q changes
    assign zero    = (q_q == {WIDTH{1'b0}});
    assign bus_out = out_en ? q_q : {WIDTH{1'bz}};

endmodule
